// File: rtl/cache_mux_types.sv
// Shared types for the pmem arbiter: FSM states, grant encoding and the latched request payload.
package cache_mux_types;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [LINE_W-1:0] wdata;
        logic              read;
        logic              write;
    } pmem_req_t;

endpackage

// File: rtl/pmem_req_reg.sv
// Load-enabled holding register for the granted pmem request; cleared by async active-low reset.
module pmem_req_reg
    import cache_mux_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_load,
    input  pmem_req_t i_req,
    output pmem_req_t o_req
);

    pmem_req_t r_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (i_load) begin
            r_req <= i_req;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one physical-memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise D always beats I.
module pmem_arbiter
    import cache_mux_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_grant_t w_grant;
    pmem_req_t  w_req_next;
    pmem_req_t  w_req;
    logic       w_load;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_busy;
    logic       r_mem_read;
    logic       r_mem_write;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;
    assign w_busy  = (r_state == I_BUSY) || (r_state == D_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t r_last_grant;

    // Ties go to whichever side lost the previous grant.
    always_comb begin
        w_grant = GRANT_I;
        if (w_i_req && w_d_req) begin
            w_grant = (r_last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (w_d_req) begin
            w_grant = GRANT_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= GRANT_D;
        end else if (w_load) begin
            r_last_grant <= w_grant;
        end
    end
`else
    always_comb begin
        w_grant = GRANT_I;
        if (w_d_req) begin
            w_grant = GRANT_D;
        end
    end
`endif

    // Payload of the winning requester; a simultaneous D read+write resolves to write.
    always_comb begin
        w_req_next = '0;
        if (w_grant == GRANT_D) begin
            w_req_next.address = ADDR_W'(d_pmem_address);
            w_req_next.wdata   = LINE_W'(d_pmem_wdata);
            w_req_next.write   = d_pmem_write;
            w_req_next.read    = d_pmem_read & ~d_pmem_write;
        end else begin
            w_req_next.address = ADDR_W'(i_pmem_address);
            w_req_next.read    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_load       = 1'b1;
                    w_next_state = (w_grant == GRANT_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    pmem_req_reg u_req_reg (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_load),
        .i_req  (w_req_next),
        .o_req  (w_req)
    );

    // Command strobes are registered so the adaptor never sees a combinational path from requesters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_load) begin
            r_mem_read  <= w_req_next.read;
            r_mem_write <= w_req_next.write;
        end else if (w_busy && mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = ADDR_WIDTH'(w_req.address);
    assign mem_wdata   = LINE_WIDTH'(w_req.wdata);

    assign i_pmem_resp  = (r_state == I_BUSY) && mem_resp;
    assign d_pmem_resp  = (r_state == D_BUSY) && mem_resp;
    assign i_pmem_rdata = (r_state == I_BUSY) ? mem_rdata : '0;
    assign d_pmem_rdata = (r_state == D_BUSY) ? mem_rdata : '0;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        (r_state == IDLE) |-> !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter (honours ARB_ROUND_ROBIN_EN for tie ordering).
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_W  = {8{32'h1234_5678}};
    localparam logic [255:0] LINE_R  = {8{32'hC0DE_0001}};
    localparam logic [255:0] LINE_FF = {256{1'b1}};

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one cycle after the grant; checks nwait stall cycles, the resp cycle and DONE.
    task automatic busy_phase(input string tag, input logic is_d, input logic [31:0] addr,
                              input logic wr, input logic [255:0] wd,
                              input logic [255:0] rd, input int nwait);
        for (int j = 0; j < nwait; j++) begin
            chk({tag, " mem_read"},  mem_read,  !wr);
            chk({tag, " mem_write"}, mem_write, wr);
            chk({tag, " mem_addr"},  mem_address, addr);
            chk({tag, " mem_wdata"}, mem_wdata, wd);
            chk({tag, " early_resp"}, i_pmem_resp | d_pmem_resp, 1'b0);
            step();
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        #1;
        chk({tag, " resp mem_read"},  mem_read,  !wr);
        chk({tag, " resp mem_write"}, mem_write, wr);
        chk({tag, " resp mem_addr"},  mem_address, addr);
        chk({tag, " i_resp"},  i_pmem_resp, !is_d);
        chk({tag, " d_resp"},  d_pmem_resp, is_d);
        chk({tag, " i_rdata"}, i_pmem_rdata, is_d ? 256'h0 : rd);
        chk({tag, " d_rdata"}, d_pmem_rdata, is_d ? rd : 256'h0);
        step();
        // Adaptor resp left high into DONE must be ignored.
        chk({tag, " done mem_read"},  mem_read,  1'b0);
        chk({tag, " done mem_write"}, mem_write, 1'b0);
        chk({tag, " done i_resp"},    i_pmem_resp, 1'b0);
        chk({tag, " done d_resp"},    d_pmem_resp, 1'b0);
        chk({tag, " done i_rdata"},   i_pmem_rdata, 256'h0);
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        rst            = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_resp       = 1'b1;
        mem_rdata      = LINE_FF;

        // Reset values, with adaptor response lines active to prove gating.
        step();
        step();
        chk("rst mem_read",  mem_read,  1'b0);
        chk("rst mem_write", mem_write, 1'b0);
        chk("rst mem_addr",  mem_address, 32'h0);
        chk("rst mem_wdata", mem_wdata, 256'h0);
        chk("rst i_resp",    i_pmem_resp, 1'b0);
        chk("rst d_resp",    d_pmem_resp, 1'b0);
        chk("rst i_rdata",   i_pmem_rdata, 256'h0);
        chk("rst d_rdata",   d_pmem_rdata, 256'h0);
        rst       = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        step();

        // Simultaneous I read and D write; D address changes while D is busy.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_0200;
        d_pmem_wdata   = LINE_W;
        #1;
        chk("tie cycle0 mem_read",  mem_read,  1'b0);
        chk("tie cycle0 mem_write", mem_write, 1'b0);
        step();
`ifdef ARB_ROUND_ROBIN_EN
        busy_phase("tie I first", 1'b0, 32'h0000_0100, 1'b0, 256'h0, LINE_R, 2);
        i_pmem_read = 1'b0;
        step();
        chk("tie idle mem_write", mem_write, 1'b0);
        step();
        d_pmem_address = 32'h0000_0300;
        busy_phase("tie D second", 1'b1, 32'h0000_0200, 1'b1, LINE_W, 256'h0, 2);
        d_pmem_write = 1'b0;
`else
        d_pmem_address = 32'h0000_0300;
        busy_phase("tie D first", 1'b1, 32'h0000_0200, 1'b1, LINE_W, 256'h0, 2);
        d_pmem_write = 1'b0;
        step();
        chk("tie idle mem_read", mem_read, 1'b0);
        step();
        busy_phase("tie I second", 1'b0, 32'h0000_0100, 1'b0, 256'h0, LINE_R, 2);
        i_pmem_read = 1'b0;
`endif
        step();

        // Spurious adaptor response while IDLE.
        mem_resp  = 1'b1;
        mem_rdata = LINE_FF;
        #1;
        chk("spur i_resp",  i_pmem_resp, 1'b0);
        chk("spur d_resp",  d_pmem_resp, 1'b0);
        chk("spur i_rdata", i_pmem_rdata, 256'h0);
        chk("spur d_rdata", d_pmem_rdata, 256'h0);
        step();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        chk("spur mem_read",  mem_read,  1'b0);
        chk("spur mem_write", mem_write, 1'b0);

        // Reset mid-BUSY abandons the transaction.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0040;
        step();
        chk("midrst busy mem_read", mem_read, 1'b1);
        chk("midrst busy mem_addr", mem_address, 32'h0000_0040);
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = LINE_FF;
        #1;
        chk("midrst mem_read", mem_read, 1'b0);
        chk("midrst mem_addr", mem_address, 32'h0);
        chk("midrst i_resp",   i_pmem_resp, 1'b0);
        chk("midrst i_rdata",  i_pmem_rdata, 256'h0);
        i_pmem_read = 1'b0;
        step();
        rst       = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        step();
        chk("postrst idle mem_read", mem_read, 1'b0);

        // Lone I read at 0x60, resp in cycle 4, request held into DONE.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0060;
        #1;
        chk("lone cycle0 mem_read", mem_read, 1'b0);
        step();
        busy_phase("lone I", 1'b0, 32'h0000_0060, 1'b0, 256'h0, LINE_A5, 3);
        step();
        i_pmem_read = 1'b0;
        chk("held idle mem_read", mem_read, 1'b0);
        step();
        chk("held no reissue", mem_read, 1'b0);
        chk("held addr kept",  mem_address, 32'h0000_0060);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
